uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 127 ++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop line synchronizer, mid-bit sampling FSM (IDLE/START/DATA/STOP),
// single-entry holding register with valid/ack handshake, frame-error and overrun pulses.
`timescale 1ns/1ps
module uart_rx #(
  parameter int SYSTEMCLOCK   = 100_000_000,
  parameter int BAUDRATE      = 115_200,
  parameter int ELEMENT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_line,
  input  logic                     rx_ack,
  output logic [ELEMENT_WIDTH-1:0] rx_data,
  output logic                     rx_valid,
  output logic                     rx_busy,
  output logic                     rx_frame_err,
  output logic                     rx_overrun
);

  localparam int CLOCKS_PER_BAUD = SYSTEMCLOCK / BAUDRATE;
  localparam int HALF_BAUD       = CLOCKS_PER_BAUD / 2;
  localparam int BIT_W           = $clog2(ELEMENT_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                   state, state_n;
  logic [31:0]              clk_cnt, clk_cnt_n;
  logic [BIT_W-1:0]         bit_cnt, bit_cnt_n;
  logic [ELEMENT_WIDTH-1:0] shift_q, shift_n;
  logic                     commit, frame_err_n;

  logic rx_meta_p0, rx_s;
  logic [1:0] flush_q;
  logic armed;

  // Synchronizer stage; armed only once rx_s has been seen high from the real line
  // after reset, so a frame already in flight at reset release is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_p0 <= 1'b1;
      rx_s       <= 1'b1;
      flush_q    <= 2'b00;
      armed      <= 1'b0;
    end else begin
      rx_meta_p0 <= rx_line;
      rx_s       <= rx_meta_p0;
      flush_q    <= {flush_q[0], 1'b1};
      armed      <= armed | (flush_q[1] & rx_s);
    end
  end

  always_comb begin
    state_n     = state;
    clk_cnt_n   = clk_cnt + 32'd1;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift_q;
    commit      = 1'b0;
    frame_err_n = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_n = '0;
        if (armed && !rx_s) state_n = START;
      end
      START: begin
        if (clk_cnt == 32'(HALF_BAUD - 1)) begin
          clk_cnt_n = '0;
          bit_cnt_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == 32'(CLOCKS_PER_BAUD - 1)) begin
          clk_cnt_n = '0;
          shift_n   = {rx_s, shift_q[ELEMENT_WIDTH-1:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == BIT_W'(ELEMENT_WIDTH - 1)) state_n = STOP;
        end
      end
      STOP: begin
        if (clk_cnt == 32'(CLOCKS_PER_BAUD - 1)) begin
          clk_cnt_n = '0;
          state_n   = IDLE;
          if (rx_s) commit = 1'b1;
          else      frame_err_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift_q <= '0;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_cnt <= bit_cnt_n;
      shift_q <= shift_n;
    end
  end

  // Output holding register; an ack coinciding with a commit absorbs the overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= frame_err_n;
      rx_overrun   <= commit & rx_valid & ~rx_ack;
      if (commit) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign rx_busy = (state != IDLE);

endmodule
